// File: rtl/fetch_req_ctrl_pkg.sv
// Shared types for the instruction-fetch request sequencer.
// State encodings match the FC_* constants used elsewhere in the core.
package fetch_req_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_WAIT = 2'd2,
    FC_HOLD = 2'd3
  } fc_state_e;

  // Word held for the IF/PD register; pc doubles as the bus address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            addr_error;
  } fetch_word_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_req_ctrl.sv
// Issues one instruction fetch at a time, buffers the returned word until
// the IF/PD register takes it, and cancels in-flight fetches on flush.
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic            pd_allow,
  input  logic            flush,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_addr_error,
  output logic            fetch_stall,
  output logic            busy
);

  fc_state_e   state_q, state_d;
  logic        drop_q, drop_d;
  fetch_word_t word_q, word_d;
  logic        hold_valid;
  logic        handoff;
  logic        start;

  // Flush beats a handoff in the same cycle.
  assign hold_valid = (state_q == FC_HOLD) && !drop_q;
  assign handoff    = hold_valid && pd_allow && !flush;
  assign start      = pc_valid && !flush && ((state_q == FC_IDLE) || handoff);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FC_IDLE;
      drop_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    word_d  = word_q;
    if (start) begin
      word_d.pc = if_pc;
      if (pc_misaligned(if_pc)) begin
        // Misaligned PC never reaches the bus; report it straight away.
        word_d.inst       = '0;
        word_d.addr_error = 1'b1;
        state_d           = FC_HOLD;
      end else begin
        word_d.addr_error = 1'b0;
        state_d           = FC_REQ;
      end
    end else begin
      unique case (state_q)
        FC_IDLE: state_d = FC_IDLE;
        FC_REQ: begin
          // The request stays up until accepted; a flush only marks it dead.
          if (flush) drop_d = 1'b1;
          if (inst_addr_ok) state_d = FC_WAIT;
        end
        FC_WAIT: begin
          if (inst_data_ok) begin
            if (drop_q || flush) begin
              drop_d  = 1'b0;
              state_d = FC_IDLE;
            end else begin
              word_d.inst       = inst_rdata;
              word_d.addr_error = 1'b0;
              state_d           = FC_HOLD;
            end
          end else if (flush) begin
            drop_d = 1'b1;
          end
        end
        FC_HOLD: begin
          if (flush || handoff) state_d = FC_IDLE;
        end
        default: state_d = FC_IDLE;
      endcase
    end
  end

  assign inst_req       = (state_q == FC_REQ);
  assign inst_addr      = word_q.pc;
  assign out_valid      = hold_valid;
  assign out_pc         = word_q.pc;
  assign out_inst       = word_q.inst;
  assign out_addr_error = word_q.addr_error;
  assign fetch_stall    = !handoff;
  assign busy           = (state_q != FC_IDLE);

endmodule
